// File: rtl/operand_seq_pkg.sv
// rtl/operand_seq_pkg.sv - shared types for the operand sequencer
package operand_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_STEP = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/operand_mem.sv
// rtl/operand_mem.sv - operand tuple table, sync write, async read, no reset
module operand_mem #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - table-driven operand tuple source on a valid/ready stream
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_OPS = 2,
    parameter  int DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int TW      = NUM_OPS * DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          mode_auto,
    input  logic          wrap_en,
    input  logic [AW-1:0] last_idx,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [TW-1:0] wr_data,
    output logic          ops_valid,
    input  logic          ops_ready,
    output logic [TW-1:0] ops_data,
    output logic [AW-1:0] ops_idx,
    output logic          busy,
    output logic          done
);

    seq_state_e    state_q, state_d;
    logic          load_q;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] last_q, last_d;
    logic          valid_q, valid_d;
    logic [TW-1:0] data_q, data_d;
    logic [AW-1:0] oidx_q, oidx_d;

    logic          trig;
    logic          xfer;
    logic          at_end;
    logic          seq_end;
    logic          load_tuple;
    logic [AW-1:0] idx_next;
    logic [TW-1:0] rd_data;

    assign trig     = load & ~load_q;
    assign xfer     = valid_q & ops_ready;
    assign at_end   = (idx_q == last_q);
    assign seq_end  = at_end & ~wrap_en;
    assign idx_next = at_end ? (wrap_en ? '0 : idx_q) : idx_q + AW'(1);

    // Reads at idx_d so a tuple is captured in the same edge that selects it.
    operand_mem #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (idx_d),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_d     = last_q;
        valid_d    = valid_q;
        oidx_d     = oidx_q;
        load_tuple = 1'b0;

        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (trig) begin
                    if (state_q == SEQ_DONE) begin
                        idx_d = '0;
                    end
                    last_d     = last_idx;
                    state_d    = mode_auto ? SEQ_RUN : SEQ_STEP;
                    load_tuple = 1'b1;
                end
            end
            SEQ_STEP: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    idx_d   = idx_next;
                    state_d = seq_end ? SEQ_DONE : SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                if (xfer) begin
                    idx_d = idx_next;
                    if (seq_end) begin
                        valid_d = 1'b0;
                        state_d = SEQ_DONE;
                    end else if (load) begin
                        load_tuple = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = SEQ_IDLE;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (load_tuple) begin
            valid_d = 1'b1;
            oidx_d  = idx_d;
        end
    end

    // Held data is a private copy, so table writes never disturb a pending tuple.
    assign data_d = load_tuple ? rd_data : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_IDLE;
            load_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            oidx_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
        end
    end

    assign ops_valid = valid_q;
    assign ops_data  = data_q;
    assign ops_idx   = oidx_q;
    assign busy      = (state_q == SEQ_STEP) || (state_q == SEQ_RUN);
    assign done      = (state_q == SEQ_DONE);

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - self-checking bench for operand_sequencer
module tb_operand_sequencer;

    localparam int AW  = 4;
    localparam int TW  = 64;
    localparam int DP  = 16;
    localparam int AWB = 3;
    localparam int TWB = 48;
    localparam int DPB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          load, mode_auto, wrap_en, wr_en, ops_ready;
    logic [AW-1:0] last_idx, wr_addr;
    logic [TW-1:0] wr_data;
    logic          ops_valid, busy, done;
    logic [TW-1:0] ops_data;
    logic [AW-1:0] ops_idx;

    logic           load_b, mode_auto_b, wrap_en_b, wr_en_b, ops_ready_b;
    logic [AWB-1:0] last_idx_b, wr_addr_b;
    logic [TWB-1:0] wr_data_b;
    logic           ops_valid_b, busy_b, done_b;
    logic [TWB-1:0] ops_data_b;
    logic [AWB-1:0] ops_idx_b;

    operand_sequencer #(.DATA_W(32), .NUM_OPS(2), .DEPTH(DP)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .mode_auto(mode_auto), .wrap_en(wrap_en),
        .last_idx(last_idx), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ops_valid(ops_valid), .ops_ready(ops_ready), .ops_data(ops_data), .ops_idx(ops_idx),
        .busy(busy), .done(done)
    );

    operand_sequencer #(.DATA_W(16), .NUM_OPS(3), .DEPTH(DPB)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load_b), .mode_auto(mode_auto_b), .wrap_en(wrap_en_b),
        .last_idx(last_idx_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .ops_valid(ops_valid_b), .ops_ready(ops_ready_b), .ops_data(ops_data_b), .ops_idx(ops_idx_b),
        .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] idx;
        logic [TW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic          load;
        logic          exp_valid;
        logic [AW-1:0] exp_idx;
        logic          exp_busy;
    } vec_t;
    vec_t vecs[9];

    logic [TW-1:0]  model   [DP];
    logic [TWB-1:0] model_b [DPB];

    localparam logic [TW-1:0]  E0     = {32'h427cfb96, 32'h401421e6};
    localparam logic [TW-1:0]  E1     = {32'hc261624e, 32'hc7f1831e};
    localparam logic [TWB-1:0] B5_OLD = 48'h1111_2222_3333;
    localparam logic [TWB-1:0] B5_NEW = {16'hA, 16'hB, 16'hC};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i);
        exp_t e;
        e.idx  = AW'(i);
        e.data = model[i];
        sb_q.push_back(e);
    endtask

    task automatic write_a(input int a, input logic [TW-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; model[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_b(input int a, input logic [TWB-1:0] d);
        wr_en_b = 1'b1; wr_addr_b = AWB'(a); wr_data_b = d; model_b[a] = d;
        tick();
        wr_en_b = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int c;
        c = 0;
        while (!done && c < 40) begin
            tick();
            c++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    // Scoreboard: every accepted tuple must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ops_valid && ops_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: idx %0d data %h, nothing expected", ops_idx, ops_data);
            end else begin
                e = sb_q.pop_front();
                check("sb_idx", 64'(ops_idx), 64'(e.idx));
                check("sb_data", ops_data, e.data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; load = 0; mode_auto = 0; wrap_en = 0; wr_en = 0; ops_ready = 0;
        last_idx = '0; wr_addr = '0; wr_data = '0;
        load_b = 0; mode_auto_b = 0; wrap_en_b = 0; wr_en_b = 0; ops_ready_b = 0;
        last_idx_b = '0; wr_addr_b = '0; wr_data_b = '0;
        tick();
        tick();
        check("rst_valid", 64'(ops_valid), 64'd0);
        check("rst_data", ops_data, 64'd0);
        check("rst_idx", 64'(ops_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        write_a(0, E0);
        write_a(1, E1);
        for (int i = 2; i < 4; i++) write_a(i, {$urandom, $urandom});

        // step mode, two pulses, stop at end
        mode_auto = 0; wrap_en = 0; last_idx = 4'd1; ops_ready = 1;
        push(0);
        load = 1; tick(); load = 0;
        check("s1_valid", 64'(ops_valid), 64'd1);
        check("s1_idx", 64'(ops_idx), 64'd0);
        check("s1_busy", 64'(busy), 64'd1);
        tick();
        check("s1_valid_fall", 64'(ops_valid), 64'd0);
        check("s1_done_early", 64'(done), 64'd0);
        push(1);
        load = 1; tick(); load = 0;
        check("s2_idx", 64'(ops_idx), 64'd1);
        tick();
        check("s2_done", 64'(done), 64'd1);
        check("s2_busy", 64'(busy), 64'd0);

        // stall with extra pulses dropped
        ops_ready = 0;
        push(0);
        load = 1; tick(); load = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) load = 1;
            if (k == 2) load = 0;
            tick();
            check("stall_data", ops_data, E0);
            check("stall_idx", 64'(ops_idx), 64'd0);
            check("stall_valid", 64'(ops_valid), 64'd1);
        end
        ops_ready = 1; tick(); ops_ready = 0;
        check("stall_release_valid", 64'(ops_valid), 64'd0);
        check("stall_release_done", 64'(done), 64'd0);
        push(1);
        load = 1; tick(); load = 0;
        check("stall_next_idx", 64'(ops_idx), 64'd1);
        ops_ready = 1; tick();
        check("stall_end_done", 64'(done), 64'd1);

        // auto mode with wrap: table of per-cycle vectors
        do_reset();
        mode_auto = 1; wrap_en = 1; last_idx = 4'd2; ops_ready = 1;
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 1'b1, AW'(i % 3), 1'b1};
            push(i % 3);
        end
        vecs[8] = '{1'b0, 1'b0, '0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            load = vecs[i].load;
            tick();
            check("vec_valid", 64'(ops_valid), 64'(vecs[i].exp_valid));
            check("vec_busy", 64'(busy), 64'(vecs[i].exp_busy));
            if (vecs[i].exp_valid) check("vec_idx", 64'(ops_idx), 64'(vecs[i].exp_idx));
        end
        check("wrap_done", 64'(done), 64'd0);

        // auto mode, stop at end, then restart from DONE
        do_reset();
        wrap_en = 0; last_idx = 4'd3;
        for (int i = 0; i < 4; i++) push(i);
        load = 1;
        wait_done("stop_done");
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_valid", 64'(ops_valid), 64'd0);
        check("stop_sb_drained", 64'(sb_q.size()), 64'd0);
        load = 0; tick();
        for (int i = 0; i < 4; i++) push(i);
        load = 1; tick();
        check("restart_done", 64'(done), 64'd0);
        check("restart_valid", 64'(ops_valid), 64'd1);
        check("restart_idx", 64'(ops_idx), 64'd0);
        wait_done("restart_end");
        load = 0;

        // reset asserted mid-RUN with load high
        do_reset();
        wrap_en = 1; last_idx = 4'd3; ops_ready = 0;
        load = 1; tick();
        check("mr_idx0", 64'(ops_idx), 64'd0);
        push(0);
        ops_ready = 1; tick(); ops_ready = 0;
        check("mr_idx1", 64'(ops_idx), 64'd1);
        #2;
        rst_n = 0;
        #1;
        check("mr_valid", 64'(ops_valid), 64'd0);
        check("mr_data", ops_data, 64'd0);
        check("mr_idx", 64'(ops_idx), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        tick();
        rst_n = 1;
        tick();
        check("mr_rel_valid", 64'(ops_valid), 64'd1);
        check("mr_rel_idx", 64'(ops_idx), 64'd0);
        check("mr_rel_data", ops_data, model[0]);
        load = 0;
        do_reset();

        // narrow instance: write to the presented entry
        for (int i = 0; i < 5; i++) write_b(i, TWB'({$urandom, $urandom}));
        write_b(5, B5_OLD);
        mode_auto_b = 1; wrap_en_b = 1; last_idx_b = 3'd5; ops_ready_b = 1;
        load_b = 1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("b_idx", 64'(ops_idx_b), 64'(k));
            check("b_data", 64'(ops_data_b), 64'(model_b[k]));
        end
        ops_ready_b = 0;
        write_b(5, B5_NEW);
        check("b_hold_data", 64'(ops_data_b), 64'(B5_OLD));
        check("b_hold_idx", 64'(ops_idx_b), 64'd5);
        ops_ready_b = 1;
        tick();
        check("b_wrap_valid", 64'(ops_valid_b), 64'd1);
        check("b_wrap_idx", 64'(ops_idx_b), 64'd0);
        for (int k = 1; k < 6; k++) tick();
        check("b_pass2_idx", 64'(ops_idx_b), 64'd5);
        check("b_pass2_data", 64'(ops_data_b), 64'(B5_NEW));
        load_b = 0;
        tick();
        check("b_stop_busy", 64'(busy_b), 64'd0);

        check("sb_final_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
